// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: redirect/exception requests in, fetch address and
// status out.
//   master: request side (pipeline control / CP0), drives the requests
//   slave : the PC generator, drives pc, pc_plus4, pend_valid, exc_code_f
interface fetch_pc_gen_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned EXCCODE_W = 5
);
  logic                 pc_en;
  logic                 redir_valid;
  logic [ADDR_W-1:0]    redir_pc;
  logic                 exc_req;
  logic                 eret_req;
  logic [ADDR_W-1:0]    epc;
  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    pc_plus4;
  logic                 pend_valid;
  logic [EXCCODE_W-1:0] exc_code_f;

  modport master (
    output pc_en, redir_valid, redir_pc, exc_req, eret_req, epc,
    input  pc, pc_plus4, pend_valid, exc_code_f
  );

  modport slave (
    input  pc_en, redir_valid, redir_pc, exc_req, eret_req, epc,
    output pc, pc_plus4, pend_valid, exc_code_f
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage program counter with stall-tolerant redirect capture and
// fetch address fault (AdEL) detection.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - fetch_pc_gen_if.slave: pc_en, redir_valid/redir_pc,
//           exc_req, eret_req/epc in; pc, pc_plus4, pend_valid, exc_code_f out
module fetch_pc_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h0000_4180),
  parameter logic [ADDR_W-1:0]  TEXT_LO   = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0]  TEXT_HI   = ADDR_W'(32'h0000_4FFC),
  parameter int unsigned        EXCCODE_W = 5,
  parameter int unsigned        ADEL_CODE = 4
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_gen_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pc_plus4_c;
  logic              fault_c;

  assign pc_plus4_c = pc_q + ADDR_W'(4);

  // Unsigned range check plus word alignment.
  assign fault_c = (pc_q < TEXT_LO) || (pc_q > TEXT_HI) || (pc_q[1:0] != 2'b00);

  // Next-PC selection: exception > eret > live redirect > pending > sequential.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    if (bus.exc_req) begin
      pc_d         = EXC_VEC;
      pend_valid_d = 1'b0;
    end else if (bus.eret_req) begin
      pc_d         = bus.epc;
      pend_valid_d = 1'b0;
    end else if (bus.pc_en) begin
      pend_valid_d = 1'b0;
      if (bus.redir_valid) begin
        pc_d = bus.redir_pc;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = pc_plus4_c;
      end
    end else if (bus.redir_valid) begin
      // Stalled: capture the redirect; a newer one replaces an older one.
      pend_pc_d    = bus.redir_pc;
      pend_valid_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VEC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4_c;
  assign bus.pend_valid = pend_valid_q;
  assign bus.exc_code_f = fault_c ? EXCCODE_W'(ADEL_CODE) : '0;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed sequence with literal expectations,
// then randomized traffic, all checked against a priority-rule model.
module tb_fetch_pc_gen;

  logic clk;
  logic reset;

  fetch_pc_gen_if #(.ADDR_W(32), .EXCCODE_W(5)) bus ();

  fetch_pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  logic        m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_pc      = 32'h0000_3000;
      m_pend    = 1'b0;
      m_pend_pc = 32'h0;
    end else if (bus.exc_req) begin
      m_pc   = 32'h0000_4180;
      m_pend = 1'b0;
    end else if (bus.eret_req) begin
      m_pc   = bus.epc;
      m_pend = 1'b0;
    end else if (bus.pc_en) begin
      if (bus.redir_valid)  m_pc = bus.redir_pc;
      else if (m_pend)      m_pc = m_pend_pc;
      else                  m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (bus.redir_valid) begin
      m_pend    = 1'b1;
      m_pend_pc = bus.redir_pc;
    end
  end

  function automatic logic [4:0] exp_code(input logic [31:0] a);
    if (a < 32'h0000_3000 || a > 32'h0000_4FFC || a % 4 != 0) return 5'd4;
    return 5'd0;
  endfunction

  // Directed literal expectations, set by the stimulus process.
  logic        check_en;
  logic        lit_on;
  logic [31:0] lit_pc;
  logic        lit_pend;
  logic [4:0]  lit_exc;
  int          lit_id;

  int checks;
  int errors;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d t=%0t actual=0x%08h required=0x%08h", name, id, $time, act, exp);
    end
  endtask

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_pc",       lit_id, bus.pc, m_pc);
      chk("model_pc_plus4", lit_id, bus.pc_plus4, m_pc + 32'd4);
      chk("model_pend",     lit_id, 32'(bus.pend_valid), 32'(m_pend));
      chk("model_exc_code", lit_id, 32'(bus.exc_code_f), 32'(exp_code(m_pc)));
      if (lit_on) begin
        chk("lit_pc",       lit_id, bus.pc, lit_pc);
        chk("lit_pend",     lit_id, 32'(bus.pend_valid), 32'(lit_pend));
        chk("lit_exc_code", lit_id, 32'(bus.exc_code_f), 32'(lit_exc));
      end
    end
  end

  // One clock with the inputs currently driven; then arm the literal check.
  task automatic cyc(input logic on, input logic [31:0] epc_v, input logic ep, input logic [4:0] ee);
    @(posedge clk);
    #2;
    lit_on   = on;
    lit_pc   = epc_v;
    lit_pend = ep;
    lit_exc  = ee;
    lit_id   = lit_id + 1;
  endtask

  task automatic idle_inputs();
    bus.pc_en       = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    bus.exc_req     = 1'b0;
    bus.eret_req    = 1'b0;
    bus.epc         = 32'h0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [6];
    edges[0] = 32'h0000_2FFC; edges[1] = 32'h0000_3000; edges[2] = 32'h0000_4FFC;
    edges[3] = 32'h0000_5000; edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h0000_3002;
    case ($urandom_range(0, 3))
      0, 1:    return 32'h0000_3000 + 32'($urandom_range(0, 2047)) * 32'd4;
      2:       return $urandom;
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    lit_on   = 1'b0;
    lit_pc   = 32'h0;
    lit_pend = 1'b0;
    lit_exc  = 5'd0;
    lit_id   = 0;
    reset    = 1'b1;
    idle_inputs();

    // Reset, then sequential fetch.
    cyc(1, 32'h3000, 0, 0);
    check_en = 1'b1;
    reset = 1'b0; bus.pc_en = 1'b1;
    cyc(1, 32'h3004, 0, 0);
    cyc(1, 32'h3008, 0, 0);
    cyc(1, 32'h300C, 0, 0);

    // Redirect during a stall, applied after release.
    bus.pc_en = 1'b0; bus.redir_valid = 1'b1; bus.redir_pc = 32'h3100;
    cyc(1, 32'h300C, 1, 0);
    bus.redir_valid = 1'b0;
    cyc(1, 32'h300C, 1, 0);
    cyc(1, 32'h300C, 1, 0);
    bus.pc_en = 1'b1;
    cyc(1, 32'h3100, 0, 0);
    bus.pc_en = 1'b0;
    cyc(1, 32'h3100, 0, 0);

    // Two redirects in one stall: newest wins.
    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3100;
    cyc(1, 32'h3100, 1, 0);
    bus.redir_pc = 32'h3200;
    cyc(1, 32'h3100, 1, 0);
    bus.redir_valid = 1'b0; bus.pc_en = 1'b1;
    cyc(1, 32'h3200, 0, 0);
    cyc(1, 32'h3204, 0, 0);

    // Exception beats eret and redirect, even while stalled.
    bus.pc_en = 1'b0; bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3010;
    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3300;
    cyc(1, 32'h4180, 0, 0);

    // Eret while stalled with a redirect pending.
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.redir_pc = 32'h3500;
    cyc(1, 32'h4180, 1, 0);
    bus.redir_valid = 1'b0; bus.eret_req = 1'b1;
    cyc(1, 32'h3010, 0, 0);
    bus.eret_req = 1'b0; bus.pc_en = 1'b1;
    cyc(1, 32'h3014, 0, 0);

    // Fault boundaries via redirect.
    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3002;
    cyc(1, 32'h3002, 0, 4);
    bus.redir_pc = 32'h5000;
    cyc(1, 32'h5000, 0, 4);
    bus.redir_pc = 32'h4FFC;
    cyc(1, 32'h4FFC, 0, 0);
    bus.redir_valid = 1'b0;
    cyc(1, 32'h5000, 0, 4);
    bus.redir_valid = 1'b1; bus.redir_pc = 32'hFFFF_FFFC;
    cyc(1, 32'hFFFF_FFFC, 0, 4);
    bus.redir_valid = 1'b0;
    cyc(1, 32'h0000_0000, 0, 4);
    bus.redir_valid = 1'b1; bus.redir_pc = 32'h2FFC;
    cyc(1, 32'h2FFC, 0, 4);
    bus.redir_pc = 32'h3000;
    cyc(1, 32'h3000, 0, 0);

    // Reset discards a pending redirect.
    bus.pc_en = 1'b0; bus.redir_pc = 32'h3600;
    cyc(1, 32'h3000, 1, 0);
    bus.redir_valid = 1'b0; reset = 1'b1;
    cyc(1, 32'h3000, 0, 0);
    reset = 1'b0; bus.pc_en = 1'b1;
    cyc(1, 32'h3004, 0, 0);
    cyc(1, 32'h3008, 0, 0);

    // Randomized traffic, model-checked only.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      bus.pc_en       = ($urandom_range(0, 3) != 0);
      bus.redir_valid = ($urandom_range(0, 3) == 0);
      bus.redir_pc    = pick_addr();
      bus.exc_req     = ($urandom_range(0, 29) == 0);
      bus.eret_req    = ($urandom_range(0, 19) == 0);
      bus.epc         = pick_addr();
      cyc(0, 32'h0, 0, 0);
    end

    idle_inputs();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
